sap1_controller: RTL
====================

# sap1_controller

Controller-sequencer for the SAP-1 datapath. It runs a six-state T-state ring (T1–T6) and decodes the 4-bit opcode from the instruction register. From these it drives every control line of the machine: program counter count and output, MAR load, RAM output, IR load and output, A/B load, adder/subtractor select and output, output register load. It also holds the machine halted after HLT until reset.

## Interface
Parameters:
- none; opcode encodings and state constants live in the shared package.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- clear  in  1  reset, asynchronous, active-high.
- opcode  in  4  IR upper nibble; valid from T4 onward.
- cp  out  1  PC count enable.
- ep  out  1  PC drive bus.
- lm  out  1  MAR load.
- ce  out  1  RAM drive bus.
- li  out  1  IR load.
- ei  out  1  IR lower nibble drive bus.
- la  out  1  A load.
- ea  out  1  A drive bus.
- su  out  1  ALU subtract select (0 = add).
- eu  out  1  ALU drive bus.
- lb  out  1  B load.
- lo  out  1  output register load.
- t_state  out  6  one-hot current T-state; bit0 = T1.
- halted  out  1  machine stopped by HLT.

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. Every other code is NOP.
- All control outputs are active-high and combinational from the T-state and opcode. Outside the listed states they are 0.
- Fetch cycle, identical for every opcode:
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Execute cycle:
  - LDA: T4 ei, lm; T5 ce, la; T6 none.
  - ADD: T4 ei, lm; T5 ce, lb; T6 eu, la.
  - SUB: as ADD, with su=1 in T6 only.
  - OUT: T4 ea, lo; T5–T6 none.
  - NOP: T4–T6 none.
  - HLT: at the rising edge that ends T4, enter HALT. HLT asserts no controls in T4.
- HALT state:
  - t_state=000000, halted=1, all controls 0.
  - Stays in HALT regardless of opcode; only clear exits.
- Ring: T1→T2→…→T6→T1. Early wrap is possible only per Configuration.
- At most one bus driver (ep, ce, ei, ea, eu) is high in any state. This is an invariant to be asserted.

## Timing
- Reset: while clear=1, t_state=000001, halted=0, and all control outputs are forced 0. After clear falls, the first cycle is T1 with ep and lm high.
- The state register updates on the rising edge. Datapath registers and the PC sample on the falling edge, mid-state, so the control word is stable for half a cycle before it is sampled.
- opcode is sampled combinationally in T4–T6 only. The IR loads on the T3 falling edge, so opcode is stable for all of T4–T6. Opcode changes during T1–T3 have no effect.
- Instruction length: 6 cycles fixed. With early wrap: LDA 5, OUT 4, NOP 4, ADD/SUB 6.
- HLT: halted rises at the edge after T4, 4 cycles after the HLT fetch began. The PC has already advanced past HLT.
- Clear mid-instruction: asynchronous return to T1 and abandonment of the instruction. A partially loaded A/B is not restored; that is the datapath's responsibility.

## Configuration
- SAP1_EARLY_WRAP_EN:
  - Defined: the ring returns to T1 after the last state with a nonzero control word, per the lengths under Timing. HLT is unaffected.
  - Undefined: every instruction takes 6 states. Control words are identical in both builds.

## Structure
- sap1_pkg holds:
  - opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - one-hot T-state constants T1..T6;
  - a control-word bit-index enum in the fixed order cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo.
- Sub-module sap1_ring_counter contains:
  - the six-bit one-hot ring;
  - a wrap input that forces T1 next;
  - a halt input that forces all-zero and holds there;
  - async active-high clear to T1.
- sap1_controller contains the decode logic and the control-word assembly.

## Test plan
- Reset: clear=1 for 3 cycles → t_state=000001, all controls 0, halted=0. Release → T1 with ep=lm=1, then T2 cp=1, then T3 ce=li=1.
- ADD (opcode=0001) after fetch → T4 ei,lm; T5 ce,lb; T6 eu,la with su=0. Next cycle is T1.
- SUB (0010) → T6 shows eu=la=su=1, and su=0 in every other state. Check the one-bus-driver invariant every cycle.
- LDA then OUT (0000, 1110) with the macro undefined → 6 cycles each. With SAP1_EARLY_WRAP_EN → 5 and 4 cycles. Control words match between the two builds.
- HLT (1111) → halted=1 and t_state=000000 after T4. Opcode toggled for 10 cycles → no change. clear pulse → T1, halted=0.
- Clear asserted mid-T5 of ADD → immediate t_state=000001 and controls 0, with no lb/la glitch after release.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, one-hot T-states and
// control-word bit positions. Optional build macro: SAP1_EARLY_WRAP_EN.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam int CW_W = 12;

    typedef enum logic [3:0] {
        CW_CP = 4'd0,
        CW_EP = 4'd1,
        CW_LM = 4'd2,
        CW_CE = 4'd3,
        CW_LI = 4'd4,
        CW_EI = 4'd5,
        CW_LA = 4'd6,
        CW_EA = 4'd7,
        CW_SU = 4'd8,
        CW_EU = 4'd9,
        CW_LB = 4'd10,
        CW_LO = 4'd11
    } cw_idx_e;

    function automatic logic [CW_W-1:0] cw_bit(input cw_idx_e idx);
        logic [CW_W-1:0] one;
        one = {{(CW_W-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring with forced wrap to T1, a sticky halt state
// (all zeros) and asynchronous clear back to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       wrap,
    input  logic       halt,
    output logic [5:0] t_state,
    output logic       halted
);

    logic [5:0] ring_reg;
    logic       halted_reg;
    logic [5:0] ring_rot;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_rot
            assign ring_rot[gi] = ring_reg[(gi + 5) % 6];
        end
    endgenerate

    // Once halted the ring stays zero until clear; halt wins over wrap.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ring_reg   <= T1;
            halted_reg <= 1'b0;
        end else if (halted_reg || halt) begin
            ring_reg   <= '0;
            halted_reg <= 1'b1;
        end else if (wrap) begin
            ring_reg   <= T1;
        end else begin
            ring_reg   <= ring_rot;
        end
    end

    assign t_state = ring_reg;
    assign halted  = halted_reg;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: decodes T-state and opcode into the control word.
// Build macro SAP1_EARLY_WRAP_EN shortens LDA/OUT/NOP by wrapping the ring early.
module sap1_controller
    import sap1_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic [5:0] t_state,
    output logic       halted
);

    logic [CW_W-1:0] cw;
    logic            wrap;
    logic            halt_req;

    sap1_ring_counter u_ring (
        .clock   (clock),
        .clear   (clear),
        .wrap    (wrap),
        .halt    (halt_req),
        .t_state (t_state),
        .halted  (halted)
    );

    assign halt_req = (t_state == T4) && (opcode == OP_HLT);

    always_comb begin
        cw = '0;
        case (t_state)
            T1: cw = cw_bit(CW_EP) | cw_bit(CW_LM);
            T2: cw = cw_bit(CW_CP);
            T3: cw = cw_bit(CW_CE) | cw_bit(CW_LI);
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_EI) | cw_bit(CW_LM);
                    OP_OUT:                 cw = cw_bit(CW_EA) | cw_bit(CW_LO);
                    default:                cw = '0;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA:         cw = cw_bit(CW_CE) | cw_bit(CW_LA);
                    OP_ADD, OP_SUB: cw = cw_bit(CW_CE) | cw_bit(CW_LB);
                    default:        cw = '0;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD:  cw = cw_bit(CW_EU) | cw_bit(CW_LA);
                    OP_SUB:  cw = cw_bit(CW_EU) | cw_bit(CW_LA) | cw_bit(CW_SU);
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
        // Clear forces a quiet bus even though the ring already shows T1.
        if (clear) begin
            cw = '0;
        end
    end

`ifdef SAP1_EARLY_WRAP_EN
    always_comb begin
        wrap = 1'b0;
        case (t_state)
            T4: wrap = (opcode != OP_LDA) && (opcode != OP_ADD) &&
                       (opcode != OP_SUB) && (opcode != OP_HLT);
            T5: wrap = (opcode == OP_LDA);
            default: wrap = 1'b0;
        endcase
    end
`else
    assign wrap = 1'b0;
`endif

    assign cp = cw[CW_CP];
    assign ep = cw[CW_EP];
    assign lm = cw[CW_LM];
    assign ce = cw[CW_CE];
    assign li = cw[CW_LI];
    assign ei = cw[CW_EI];
    assign la = cw[CW_LA];
    assign ea = cw[CW_EA];
    assign su = cw[CW_SU];
    assign eu = cw[CW_EU];
    assign lb = cw[CW_LB];
    assign lo = cw[CW_LO];

endmodule
